bin2bcd_serial: RTL and testbench

Iterative shift-add-3 (double-dabble) binary-to-BCD converter feeding the four-digit seven-segment display controller. It takes a binary count from the counter stage, converts it over BIN_W clock cycles, and presents four registered BCD digits. The display mux selects these digits directly, which replaces its per-digit divide/modulo logic.

---
 rtl/bin2bcd_serial_pkg.sv | 24 ++
 rtl/bin2bcd_serial_if.sv | 40 ++++
 rtl/bin2bcd_serial_adjust.sv | 17 +
 rtl/bin2bcd_serial.sv | 122 ++++++++++++
 tb/tb_bin2bcd_serial.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/bin2bcd_serial_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bin2bcd_serial_pkg                                               |
// | Brief    : Shared types, constants and sizing helper for bin2bcd_serial.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package bin2bcd_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_NINE   = 4'h9;
    localparam int         DEF_DIGITS = 4;

    // ceil(bin_w * log10(2)) in fixed point; log10(2) ~= 0.30103
    function automatic int calc_nscr(input int bin_w);
        return (bin_w * 30103 + 99999) / 100000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_serial_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bin2bcd_serial_if                                                |
// | Brief    : Request/result bundle between the counter stage and converter.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface bin2bcd_serial_if
    import bin2bcd_serial_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = DEF_DIGITS
) ();

    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  ready;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    modport master (
        output start,
        output bin_in,
        input  ready,
        input  done,
        input  bcd_out,
        input  overflow
    );

    modport slave (
        input  start,
        input  bin_in,
        output ready,
        output done,
        output bcd_out,
        output overflow
    );

endinterface
`default_nettype wire

// File: rtl/bin2bcd_serial_adjust.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bcd_adjust_digit                                                 |
// | Brief    : Double-dabble nibble correction: add 3 when the digit is >= 5.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bcd_adjust_digit (
    input  wire logic [3:0] din,
    output logic      [3:0] dout
);

    always_comb begin
        dout = (din >= 4'd5) ? (din + 4'd3) : din;
    end

endmodule
`default_nettype wire

// File: rtl/bin2bcd_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bin2bcd_serial                                                   |
// | Brief    : Iterative shift-add-3 binary-to-BCD converter, BIN_W cycles/run. |
// |            Define BCD_SATURATE_EN to force all-nines output on overflow.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bin2bcd_serial
    import bin2bcd_serial_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = DEF_DIGITS
) (
    input  wire logic         clock_100Mhz,
    input  wire logic         reset,
    bin2bcd_serial_if.slave   bus
);

    localparam int NSCR  = calc_nscr(BIN_W);
    localparam int PAD_N = (NSCR > DIGITS) ? NSCR : DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    state_t                state;
    state_t                state_next;
    logic                  accept;
    logic [CNT_W-1:0]      cnt;
    logic [BIN_W-1:0]      scr_bin;
    logic [4*NSCR-1:0]     scr_bcd;
    logic [4*NSCR-1:0]     adj_bcd;
    logic [4*PAD_N-1:0]    bcd_pad;
    logic [4*DIGITS-1:0]   bcd_next;
    logic                  ovf;
    logic                  ready_q;
    logic                  done_q;
    logic [4*DIGITS-1:0]   bcd_q;
    logic                  ovf_q;

    generate
        for (genvar i = 0; i < NSCR; i++) begin : g_adj
            bcd_adjust_digit u_adj (
                .din  (scr_bcd[4*i +: 4]),
                .dout (adj_bcd[4*i +: 4])
            );
        end
    endgenerate

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && ready_q) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(BIN_W - 1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Digits above DIGITS only feed the overflow flag
    always_comb begin
        bcd_pad              = '0;
        bcd_pad[4*NSCR-1:0]  = scr_bcd;
        ovf                  = |(bcd_pad >> (4 * DIGITS));
`ifdef BCD_SATURATE_EN
        bcd_next = ovf ? {DIGITS{BCD_NINE}} : bcd_pad[4*DIGITS-1:0];
`else
        bcd_next = bcd_pad[4*DIGITS-1:0];
`endif
    end

    always_ff @(posedge clock_100Mhz) begin
        if (!reset) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt     <= '0;
            scr_bin <= '0;
            scr_bcd <= '0;
        end else begin
            state   <= state_next;
            done_q  <= 1'b0;
            // ready stays low through the done cycle so a start there is dropped
            ready_q <= (state_next == IDLE) && (state != DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        scr_bin <= bus.bin_in;
                        scr_bcd <= '0;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    {scr_bcd, scr_bin} <= {adj_bcd, scr_bin} << 1;
                    cnt                <= cnt + 1'b1;
                end
                DONE: begin
                    bcd_q  <= bcd_next;
                    ovf_q  <= ovf;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_bin2bcd_serial                                                |
// | Brief    : Scoreboard bench for bin2bcd_serial (BCD_SATURATE_EN aware).     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_bin2bcd_serial;

    localparam int BIN_W  = 16;
    localparam int DIGITS = 4;
    localparam int LAT    = BIN_W + 1;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [16:0] exp_q[$];

    bin2bcd_serial_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin2bcd_serial #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clock_100Mhz (clk),
        .reset        (reset),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {overflow, bcd} built from decimal arithmetic
    function automatic logic [16:0] model(input int unsigned v);
        logic [15:0]  b;
        int unsigned  m;
        logic         o;
        o = (v > 9999);
        m = v % 10000;
        b = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
`ifdef BCD_SATURATE_EN
        if (o) b = 16'h9999;
`endif
        return {o, b};
    endfunction

    always @(negedge clk) begin
        if (reset && bus.done) begin
            logic [16:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got bcd=%h ovf=%b, required no done", bus.bcd_out, bus.overflow);
            end else begin
                e = exp_q.pop_front();
                if (bus.bcd_out !== e[15:0]) begin
                    errors++;
                    $display("FAIL bcd_out: got %h, required %h", bus.bcd_out, e[15:0]);
                end
                checks++;
                if (bus.overflow !== e[16]) begin
                    errors++;
                    $display("FAIL overflow: got %b, required %b", bus.overflow, e[16]);
                end
            end
        end
    end

    // Returns at the negedge just after the accepting edge
    task automatic issue(input logic [15:0] v, input bit expect_done);
        @(negedge clk);
        bus.bin_in = v;
        bus.start  = 1'b1;
        if (expect_done) exp_q.push_back(model(v));
        @(negedge clk);
        bus.start  = 1'b0;
        bus.bin_in = 16'($urandom);
    endtask

    task automatic wait_done(input string name, output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL %s latency: got %0d, required %0d", name, lat, LAT);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks += 4;
        if (bus.ready !== 1'b1)        begin errors++; $display("FAIL rst_ready: got %b, required 1", bus.ready); end
        if (bus.done !== 1'b0)         begin errors++; $display("FAIL rst_done: got %b, required 0", bus.done); end
        if (bus.bcd_out !== 16'h0000)  begin errors++; $display("FAIL rst_bcd: got %h, required 0000", bus.bcd_out); end
        if (bus.overflow !== 1'b0)     begin errors++; $display("FAIL rst_ovf: got %b, required 0", bus.overflow); end
    endtask

    task automatic test_convert(input logic [15:0] v);
        int lat;
        issue(v, 1'b1);
        wait_done($sformatf("conv_%0d", v), lat);
        checks++;
        if (bus.ready !== 1'b0) begin errors++; $display("FAIL ready_in_done: got %b, required 0", bus.ready); end
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1) begin errors++; $display("FAIL ready_after_done: got %b, required 1", bus.ready); end
    endtask

    task automatic test_ignored_start();
        int lat;
        issue(16'd42, 1'b1);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
            if (lat == 5) begin bus.start = 1'b1; bus.bin_in = 16'd7; end
            if (lat == 6) begin bus.start = 1'b0; end
        end
        checks++;
        if (lat != LAT) begin errors++; $display("FAIL ignored_latency: got %0d, required %0d", lat, LAT); end
        bus.start  = 1'b1;
        bus.bin_in = 16'd99;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (25) @(negedge clk);
        checks++;
        if (bus.bcd_out !== 16'h0042) begin errors++; $display("FAIL held_bcd: got %h, required 0042", bus.bcd_out); end
    endtask

    task automatic test_reset_mid();
        issue(16'd4321, 1'b0);
        repeat (7) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks += 4;
        if (bus.ready !== 1'b1)       begin errors++; $display("FAIL mid_ready: got %b, required 1", bus.ready); end
        if (bus.done !== 1'b0)        begin errors++; $display("FAIL mid_done: got %b, required 0", bus.done); end
        if (bus.bcd_out !== 16'h0000) begin errors++; $display("FAIL mid_bcd: got %h, required 0000", bus.bcd_out); end
        if (bus.overflow !== 1'b0)    begin errors++; $display("FAIL mid_ovf: got %b, required 0", bus.overflow); end
        repeat (25) @(negedge clk);
        test_convert(16'd56);
    endtask

    task automatic test_back_to_back();
        int n_done;
        int cyc;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = 16'd100;
        exp_q.push_back(model(100));
        exp_q.push_back(model(200));
        @(negedge clk);
        bus.bin_in = 16'd200;
        n_done = 0;
        cyc    = 0;
        while (n_done < 2 && cyc < 80) begin
            if (bus.done === 1'b1) n_done++;
            if (n_done == 1 && bus.ready === 1'b1) bus.start = 1'b1;
            @(negedge clk);
            cyc++;
            if (n_done == 1 && bus.ready === 1'b0) bus.start = 1'b0;
        end
        bus.start = 1'b0;
        checks++;
        if (n_done != 2) begin errors++; $display("FAIL b2b_count: got %0d, required 2", n_done); end
        repeat (25) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_convert(16'd0);
        test_convert(16'd1234);
        test_convert(16'd9999);
        test_convert(16'd12345);
        test_convert(16'd65535);
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL missing_done: got %0d pending, required 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
